audio_sample_packetizer: RTL

Buffers multichannel PCM frames from the audio clock-crossing stage and assembles HDMI Audio Sample Packets (type 0x02) for the packet scheduler. It owns the IEC 60958 192-frame counter and inserts per-channel channel-status, user, validity and parity bits. It generalises the single-shot combinational packet former to 2–8 channels, selects layout 0 or 1 automatically, and adds FIFO buffering and a ready/ack handshake.

---
 rtl/audio_sample_packetizer.sv | 118 +++++++++++
 1 files changed

// File: rtl/audio_sample_packetizer.sv
// audio_sample_packetizer: buffers PCM frames and forms HDMI audio sample packets with IEC 60958 status bits
module audio_sample_packetizer #(
    parameter int CHANNEL_COUNT = 2,
    parameter int SAMPLE_WIDTH = 24,
    parameter int FIFO_DEPTH = 8,
    parameter logic [3:0] SAMPLING_FREQUENCY = 4'b0010,
    parameter logic [3:0] WORD_LENGTH = 4'b1011
) (
    input  logic                                    clk_pixel,
    input  logic                                    reset,
    input  logic                                    sample_valid,
    output logic                                    sample_ready,
    input  logic [CHANNEL_COUNT*SAMPLE_WIDTH-1:0]   sample_word,
    output logic                                    packet_ready,
    input  logic                                    packet_ack,
    output logic [23:0]                             header,
    output logic [223:0]                            sub
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PAIRS = CHANNEL_COUNT / 2;
    localparam logic LAYOUT = CHANNEL_COUNT > 2;

    logic [CHANNEL_COUNT*SAMPLE_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, rd_q, rd_d;
    logic [AW:0] cnt_q, cnt_d;
    logic full_q, push, form, pkt_q, pkt_d;
    logic [2:0] n;
    logic [7:0] fc_q, fc_d, idx;
    logic [8:0] s;
    logic [3:0] sp, b;
    logic [8*SAMPLE_WIDTH-1:0] fr;
    logic [23:0] hdr_q, hdr_d;
    logic [223:0] sub_q, sub_d;

    function automatic logic cs_bit(input logic [3:0] ch, input logic [7:0] i);
        return i == 8'd2
            || (i >= 8'd20 && i <= 8'd23 && ch[i[1:0]])
            || (i >= 8'd24 && i <= 8'd27 && SAMPLING_FREQUENCY[i[1:0]])
            || (i >= 8'd32 && i <= 8'd35 && WORD_LENGTH[i[1:0]]);
    endfunction

    function automatic logic [23:0] align(input logic [SAMPLE_WIDTH-1:0] v);
        return 24'(v) << (24 - SAMPLE_WIDTH);
    endfunction

    function automatic logic [55:0] subpkt(input logic [23:0] l, input logic [23:0] r, input logic cl, input logic cr);
        return {^{r, cr}, cr, 2'b00, ^{l, cl}, cl, 2'b00, r, l};
    endfunction

    assign sample_ready = !full_q && !reset;
    assign push = sample_valid && sample_ready;
    assign form = !pkt_q && cnt_q != '0;
    assign n = LAYOUT ? 3'd1 : (cnt_q > (AW+1)'(4) ? 3'd4 : 3'(cnt_q));
    assign rd_d = form ? rd_q + AW'(n) : rd_q;
    assign cnt_d = cnt_q + (AW+1)'(push) - (form ? (AW+1)'(n) : '0);
    assign packet_ready = pkt_q;
    assign header = hdr_q;
    assign sub = sub_q;

    // Build the next packet from the FIFO head whenever the output slot is free
    always_comb begin
        pkt_d = pkt_q && !packet_ack;
        hdr_d = hdr_q;
        sub_d = sub_q;
        fc_d = fc_q;
        sp = '0;
        b = '0;
        fr = '0;
        idx = '0;
        s = '0;
        if (form) begin
            for (int k = 0; k < 4; k++) begin
                fr = (8*SAMPLE_WIDTH)'(mem_q[LAYOUT ? rd_q : rd_q + AW'(k)]);
                s = {1'b0, fc_q} + (LAYOUT ? 9'd0 : 9'(k));
                idx = s >= 9'd192 ? 8'(s - 9'd192) : s[7:0];
                sp[k] = LAYOUT ? (k < PAIRS) : (3'(k) < n);
                b[k] = sp[k] && idx == 8'd0 && (!LAYOUT || k == 0);
                sub_d[k*56 +: 56] = sp[k] ? subpkt(
                    align(fr[(LAYOUT ? 2*k : 0)*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
                    align(fr[(LAYOUT ? 2*k+1 : 1)*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
                    cs_bit(LAYOUT ? 4'(2*k+1) : 4'd1, idx),
                    cs_bit(LAYOUT ? 4'(2*k+2) : 4'd2, idx)) : 56'd0;
            end
            s = {1'b0, fc_q} + 9'(n);
            fc_d = s >= 9'd192 ? 8'(s - 9'd192) : s[7:0];
            hdr_d = {b, 7'd0, LAYOUT, sp, 8'h02};
            pkt_d = 1'b1;
        end
    end

    // Pointer, occupancy, frame counter and packet register state
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
            full_q <= 1'b0;
            pkt_q <= 1'b0;
            fc_q <= '0;
            hdr_q <= '0;
            sub_q <= '0;
        end else begin
            wr_q <= wr_q + AW'(push);
            rd_q <= rd_d;
            cnt_q <= cnt_d;
            full_q <= cnt_d == (AW+1)'(FIFO_DEPTH);
            pkt_q <= pkt_d;
            fc_q <= fc_d;
            hdr_q <= hdr_d;
            sub_q <= sub_d;
        end
    end

    // Frame storage; writes are already blocked while in reset or full
    always_ff @(posedge clk_pixel) begin
        if (push) mem_q[wr_q] <= sample_word;
    end
endmodule
